// File: rtl/hex_scan_ctrl.sv
// -----------------------------------------------------------------------------
// hex_scan_ctrl
//
// Memory-mapped seven-segment display controller. It holds DIGITS 4-bit digit
// registers, a per-digit enable mask and a write-only soft-reset register. It
// time-multiplexes the digits with its own scan counter and hex decoder.
//
// Register map (addr_i[23:0]; all other address bits are ignored):
//   0x00 + 4*k  DIGIT[k]  (k < DIGITS), 4 bits, read/write
//   0x40        MASK      DIGITS bits, read/write, reset all ones
//   0x44        RESET     write-only; any write is a one-cycle soft reset
//   0x48        BLINK     DIGITS bits, read/write (only with BLINK_EN)
// Reads of RESET and of unmapped addresses return 0.
//
// Optional feature macro: BLINK_EN
//   defined   : BLINK register, free-running blink counter over BLINK_DIV and a
//               phase bit. When phase=1 and BLINK[idx]=1 the digit is blanked.
//   undefined : no blink logic. 0x48 behaves as an unmapped address.
//
// Parameters:
//   DIGITS     number of digits, 1..16
//   SCAN_DIV   clock cycles each digit stays selected, >= 2
//   BLINK_DIV  clock cycles per blink half-period (BLINK_EN only)
//
// Ports:
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   req_i           bus request
//   write_enable_i  1 = write, 0 = read
//   addr_i          byte address
//   write_data_i    write data
//   read_data_o     registered read data, 1-cycle latency, held when idle
//   hex_led_o       segments {g,f,e,d,c,b,a}, active low
//   hex_sel_o       digit anodes, active low, at most one bit low
// -----------------------------------------------------------------------------
module hex_scan_ctrl #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN_DIV  = 1024,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              write_enable_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       write_data_i,
  output logic [31:0]       read_data_o,
  output logic [6:0]        hex_led_o,
  output logic [DIGITS-1:0] hex_sel_o
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = $clog2(SCAN_DIV);

  localparam logic [23:0] MASK_ADDR  = 24'h40;
  localparam logic [23:0] RESET_ADDR = 24'h44;

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [23:0]       addr;
  logic              wr;
  logic              rd;
  logic              soft_rst;
  logic              mask_we;
  logic [DIGITS-1:0] digit_hit;

  assign addr     = addr_i[23:0];
  assign wr       = req_i & write_enable_i;
  assign rd       = req_i & ~write_enable_i;
  assign soft_rst = wr && (addr == RESET_ADDR);
  assign mask_we  = wr && (addr == MASK_ADDR);

  // NOTE: every variable written in always_comb gets a default before any
  // conditional assignment, otherwise the tool infers a latch.
  always_comb begin
    digit_hit = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      digit_hit[k] = (addr == 24'(4 * k));
    end
  end

  // ---------------------------------------------------------------------------
  // Digit and mask registers
  // ---------------------------------------------------------------------------
  logic [3:0]        digit_q [DIGITS];
  logic [DIGITS-1:0] mask_q;

  // NOTE: the digit array is only DIGITS x 4 flops and soft reset must clear
  // it anyway, so it gets a real reset rather than being treated as RAM.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < int'(DIGITS); k++) digit_q[k] <= '0;
      mask_q <= '1;
    end else if (soft_rst) begin
      for (int k = 0; k < int'(DIGITS); k++) digit_q[k] <= '0;
      mask_q <= '1;
    end else if (wr) begin
      for (int k = 0; k < int'(DIGITS); k++) begin
        if (digit_hit[k]) digit_q[k] <= write_data_i[3:0];
      end
      if (mask_we) mask_q <= write_data_i[DIGITS-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Scan counter and digit index
  // ---------------------------------------------------------------------------
  logic [CW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic          scan_wrap;
  logic          idx_last;

  assign scan_wrap = (scan_cnt == CW'(SCAN_DIV - 1));
  assign idx_last  = (idx == IW'(DIGITS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (soft_rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= idx_last ? '0 : idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Optional blink logic
  // ---------------------------------------------------------------------------
  logic blank_blink;

`ifdef BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [23:0] BLINK_ADDR = 24'h48;

  logic [DIGITS-1:0] blink_q;
  logic [BW-1:0]     blink_cnt;
  logic              phase;
  logic              cur_blink;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blink_q   <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (soft_rst) begin
      blink_q   <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      if (wr && (addr == BLINK_ADDR)) blink_q <= write_data_i[DIGITS-1:0];
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign blank_blink = phase & cur_blink;
`else
  assign blank_blink = 1'b0;

  // BLINK_DIV only shapes hardware when blinking is built.
  logic unused_blink_div;
  assign unused_blink_div = ^BLINK_DIV;
`endif

  // Address bits above 23 and data bits above the widest register are
  // deliberately ignored.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{addr_i[31:24], write_data_i[31:4]};

  // ---------------------------------------------------------------------------
  // Display: select the current digit and register the drivers
  // ---------------------------------------------------------------------------
  logic [3:0]        cur_digit;
  logic              cur_mask;
  logic [DIGITS-1:0] sel_onehot;
  logic [DIGITS-1:0] sel_next;

  always_comb begin
    cur_digit  = '0;
    cur_mask   = 1'b0;
    sel_onehot = '0;
`ifdef BLINK_EN
    cur_blink  = 1'b0;
`endif
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (idx == IW'(k)) begin
        cur_digit     = digit_q[k];
        cur_mask      = mask_q[k];
        sel_onehot[k] = 1'b1;
`ifdef BLINK_EN
        cur_blink     = blink_q[k];
`endif
      end
    end
    sel_next = (cur_mask && !blank_blink) ? ~sel_onehot : '1;
  end

  // Outputs are registered from idx and the current register contents, so a
  // register write shows on the pins one cycle after it lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hex_sel_o <= '1;
      hex_led_o <= 7'h7F;
    end else begin
      hex_sel_o <= sel_next;
      hex_led_o <= seg_decode(cur_digit);
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (digit_hit[k]) rd_mux = {28'b0, digit_q[k]};
    end
    if (addr == MASK_ADDR) rd_mux = 32'(mask_q);
`ifdef BLINK_EN
    if (addr == BLINK_ADDR) rd_mux = 32'(blink_q);
`endif
  end

  // Soft reset leaves read data alone; only reads update it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_data_o <= '0;
    end else if (rd) begin
      read_data_o <= rd_mux;
    end
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hex_scan_ctrl
//
// Self-checking bench for hex_scan_ctrl with DIGITS=4, SCAN_DIV=4, BLINK_DIV=8.
// A behavioural model tracks the register contents and the number of cycles
// since the scan was last restarted; the selected digit is derived from that
// count by division, and expected pins/read data follow from the register map.
// Directed steps from the test plan are followed by a randomized bus phase.
// -----------------------------------------------------------------------------
module tb_hex_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;

  logic              clk;
  logic              rst_n;
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [6:0]        led;
  logic [DIGITS-1:0] sel;

  int checks   = 0;
  int failures = 0;

  hex_scan_ctrl #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .write_enable_i(we),
    .addr_i        (addr),
    .write_data_i  (wdata),
    .read_data_o   (rdata),
    .hex_led_o     (led),
    .hex_sel_o     (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low font {g,f,e,d,c,b,a}, written out from the display table.
  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int                m_digit [DIGITS];
  int                m_mask;
  int                m_blink;
  int                scan_t;   // cycles since the scan last restarted
  int                blink_t;  // cycles since the blink timer last restarted
  logic [DIGITS-1:0] exp_sel;
  logic [6:0]        exp_led;
  logic [31:0]       exp_rd;

  function automatic int model_idx();
    return (scan_t / SCAN_DIV) % DIGITS;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int a24;
    a24 = int'(a[23:0]);
    if ((a24 % 4 == 0) && (a24 < 4 * DIGITS)) return 32'(m_digit[a24 / 4]);
    if (a24 == 'h40) return 32'(m_mask);
`ifdef BLINK_EN
    if (a24 == 'h48) return 32'(m_blink);
`endif
    return 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DIGITS; i++) m_digit[i] = 0;
    m_mask  = (1 << DIGITS) - 1;
    m_blink = 0;
    scan_t  = 0;
    blink_t = 0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    int a24;
    a24 = int'(a[23:0]);
    if ((a24 % 4 == 0) && (a24 < 4 * DIGITS)) m_digit[a24 / 4] = int'(d[3:0]);
    else if (a24 == 'h40) m_mask = int'(d) & ((1 << DIGITS) - 1);
    else if (a24 == 'h44) model_clear();
`ifdef BLINK_EN
    else if (a24 == 'h48) m_blink = int'(d) & ((1 << DIGITS) - 1);
`endif
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear();
      exp_sel = '1;
      exp_led = 7'h7F;
      exp_rd  = 32'h0;
    end else begin
      int cur;
      bit blank;
      cur   = model_idx();
      blank = ((m_mask >> cur) & 1) == 0;
`ifdef BLINK_EN
      if (((blink_t / BLINK_DIV) % 2 == 1) && (((m_blink >> cur) & 1) == 1)) blank = 1'b1;
`endif
      exp_sel = blank ? '1 : ~(DIGITS'(1) << cur);
      exp_led = seg_ref[m_digit[cur]];
      if (req && !we) exp_rd = model_read(addr);
      scan_t  = scan_t + 1;
      blink_t = blink_t + 1;
      if (req && we) model_write(addr, wdata);
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // One bus cycle: drive at a falling edge, let the rising edge happen, then
  // compare every output against the model at the next falling edge.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    req   = r;
    we    = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    check("hex_sel", 32'(sel), 32'(exp_sel));
    check("hex_led", 32'(led), 32'(exp_led));
    check("read_data", rdata, exp_rd);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [31:0] a);
    step(1'b1, 1'b0, a, 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [6:0]  font_123f [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0001110};
  logic [23:0] addr_pool [10] = '{24'h00, 24'h04, 24'h08, 24'h0C, 24'h10,
                                  24'h30, 24'h3C, 24'h40, 24'h44, 24'h48};

  initial begin
    int seen [DIGITS];
    int blank_cycles;
    int waited;
    bit found;

    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_sel", 32'(sel), 32'h0000_000F);
    check("rst_led", 32'(led), 32'h0000_007F);
    check("rst_rd", rdata, 32'h0);
    rst_n = 1'b1;

    rd_reg(32'h40);
    check("rd_mask_reset", rdata, 32'h0000_000F);

    // Digits 1,2,3,F: every slot must appear exactly 4 times in 16 cycles with
    // the matching glyph.
    wr_reg(32'h00, 32'h1);
    wr_reg(32'h04, 32'h2);
    wr_reg(32'h08, 32'h3);
    wr_reg(32'h0C, 32'hF);
    for (int i = 0; i < DIGITS; i++) seen[i] = 0;
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < DIGITS; k++) begin
        if (sel == ~(DIGITS'(1) << k)) begin
          seen[k]++;
          check("scan_glyph", 32'(led), 32'(font_123f[k]));
        end
      end
    end
    for (int k = 0; k < DIGITS; k++) check("scan_slot_len", 32'(seen[k]), 32'd4);

    // MASK=0x5 blanks digits 1 and 3, i.e. half of every full scan.
    wr_reg(32'h40, 32'h5);
    rd_reg(32'h40);
    check("rd_mask_5", rdata, 32'h5);
    blank_cycles = 0;
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0);
      if (sel == 4'b1111) blank_cycles++;
    end
    check("mask_blank_cycles", 32'(blank_cycles), 32'd8);

    // Digit write/read-back, unmapped reads and writes.
    wr_reg(32'h08, 32'hA);
    rd_reg(32'h08);
    check("rd_digit2", rdata, 32'h0000_000A);
    rd_reg(32'h10);
    check("rd_unmapped_10", rdata, 32'h0);
    wr_reg(32'h30, 32'hFFFF_FFFF);
    rd_reg(32'h00);
    check("rd_digit0_after_30", rdata, 32'h1);
    rd_reg(32'h04);
    check("rd_digit1_after_30", rdata, 32'h2);
    rd_reg(32'h0C);
    check("rd_digit3_after_30", rdata, 32'hF);
    rd_reg(32'h40);
    check("rd_mask_after_30", rdata, 32'h5);
    rd_reg(32'hAB00_0008);
    check("rd_high_addr_ignored", rdata, 32'hA);

    // Soft reset in the middle of the idx=2 slot.
    found  = 1'b0;
    waited = 0;
    while (!found && waited < 64) begin
      if (model_idx() == 2 && (scan_t % SCAN_DIV) == 1) found = 1'b1;
      else begin
        step(1'b0, 1'b0, 32'h0, 32'h0);
        waited++;
      end
    end
    check("reach_idx2", 32'(found), 32'd1);
    wr_reg(32'h44, 32'h1);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    check("srst_sel", 32'(sel), 32'h0000_000E);
    check("srst_led", 32'(led), 32'h0000_0040);
    rd_reg(32'h08);
    check("srst_rd_digit2", rdata, 32'h0);
    rd_reg(32'h40);
    check("srst_rd_mask", rdata, 32'hF);
    rd_reg(32'h44);
    check("rd_reset_reg", rdata, 32'h0);

    // Blink register, or its absence.
    wr_reg(32'h04, 32'h7);
    wr_reg(32'h48, 32'h2);
    rd_reg(32'h48);
`ifdef BLINK_EN
    check("rd_blink", rdata, 32'h2);
`else
    check("rd_blink_absent", rdata, 32'h0);
`endif
    for (int c = 0; c < 48; c++) step(1'b0, 1'b0, 32'h0, 32'h0);

    // Randomized bus traffic against the model.
    for (int c = 0; c < 400; c++) begin
      int          kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 3));
      a    = {8'($urandom), addr_pool[$urandom_range(0, 9)]};
      if (kind == 3 && a[23:0] == 24'h44 && $urandom_range(0, 3) != 0) kind = 2;
      case (kind)
        0, 1:    step(1'b0, 1'b0, 32'h0, 32'h0);
        2:       rd_reg(a);
        default: wr_reg(a, $urandom);
      endcase
    end

    // Asynchronous reset mid-cycle blanks the display without a clock edge.
    wr_reg(32'h40, 32'hF);
    rd_reg(32'h40);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sel", 32'(sel), 32'h0000_000F);
    check("async_rst_led", 32'(led), 32'h0000_007F);
    check("async_rst_rd", rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
